// File: rtl/laser_tx_arbiter.sv
//-----------------------------------------------------------------------------
// laser_tx_arbiter
//
// Purpose:
//   Shares one laser transmitter between two byte requesters. Port 0 carries
//   link control/ACK bytes and port 1 carries payload bytes. The block
//   arbitrates in IDLE, latches the winning byte, pulses the transmitter's
//   data_ready for one cycle, waits for its done pulse, and then holds off
//   for GAP_CYCLES idle cycles. A frame whose done never arrives is aborted
//   after TIMEOUT_CYCLES cycles in SEND.
//
// Ports:
//   clock       single clock (transmitter clock_base domain)
//   reset       synchronous, active-low reset
//   link_en     global link enable
//   req0_*      control byte request (valid/data in, ready out)
//   req1_*      payload byte request (valid/data in, ready out)
//   tx_en       registered transmitter enable
//   tx_data     byte presented to the transmitter
//   tx_ready    one-cycle data_ready pulse
//   tx_done     transmitter frame-complete pulse
//   grant       one-hot owner of the current frame, 0 when idle
//   busy        high in every state except IDLE
//   timeout     one-cycle pulse when a frame is aborted
//
// Build option:
//   LASER_ARB_RR_EN  defined   -> round-robin arbitration between the ports
//                    undefined -> fixed priority, port 0 always wins
//-----------------------------------------------------------------------------
module laser_tx_arbiter #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CW             = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       link_en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam bit            GAP_EN       = (GAP_CYCLES != 0);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = GAP_EN ? CW'(GAP_CYCLES - 1) : '0;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    tx_data_q;
    logic [1:0]    grant_q;
    logic          tx_en_q;
    logic          tx_ready_q;
    logic          busy_q;

    logic          pick1;
    logic          accept;
    logic          abort;

    // Arbitration: pick1 selects port 1 as the winner when a request exists.
`ifdef LASER_ARB_RR_EN
    logic last1_q;  // 1 = port 1 was granted most recently

    // Under contention the port not granted last wins; a lone requester
    // always wins.
    assign pick1 = req1_valid & (~req0_valid | ~last1_q);
`else
    assign pick1 = req1_valid & ~req0_valid;
`endif

    // Readies are combinational so the requester sees acceptance in the same
    // cycle. They are gated by reset so nothing is accepted while held.
    assign accept     = reset & link_en & (state_q == S_IDLE) & (req0_valid | req1_valid);
    assign req0_ready = accept & ~pick1;
    assign req1_ready = accept &  pick1;

    // Abort only when neither a link drop nor a done pulse takes precedence.
    assign abort   = reset & link_en & ~tx_done & (state_q == S_SEND) & (cnt_q == TIMEOUT_LAST);
    assign timeout = abort;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            tx_en_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef LASER_ARB_RR_EN
            last1_q    <= 1'b1;
`endif
        end else begin
            // Dropping tx_en for one cycle after an abort clears the
            // transmitter's internal bit counter.
            tx_en_q    <= link_en & ~abort;
            tx_ready_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tx_data_q  <= pick1 ? req1_data : req0_data;
                        grant_q    <= pick1 ? 2'b10 : 2'b01;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_LOAD;
`ifdef LASER_ARB_RR_EN
                        last1_q    <= pick1;
`endif
                    end
                end

                S_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= S_SEND;
                end

                S_SEND: begin
                    if (!link_en) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (tx_done || (cnt_q == TIMEOUT_LAST)) begin
                        // Normal completion and abort share the same exit.
                        cnt_q <= '0;
                        if (GAP_EN) begin
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_GAP: begin
                    if (!link_en || (cnt_q == GAP_LAST)) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign tx_ready = tx_ready_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule
